lzrw1_stream_decompressor: RTL

Parametrised LZRW1 decompression core that succeeds `decompressor_top`. It accepts one 16-bit compressed item per handshake, together with that item's control bit, and emits a byte stream. Literals pass straight through. Copy items are expanded from an on-chip history window. The output side has valid/ready backpressure, overlapping copies are supported, and bad offsets are reported through a sticky error flag. It sits between the control-word/item unpacker and the byte sink.

---
 rtl/lzrw1_pkg.sv | 19 +
 rtl/lzrw1_history_ram.sv | 22 ++
 rtl/lzrw1_stream_decompressor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lzrw1_pkg.sv
// Shared types and default parameters for the LZRW1 stream decompressor.
// The item layout struct reflects the default 4-bit length / 12-bit offset split.
package lzrw1_pkg;

  localparam int DEFAULT_OFFSET_WIDTH = 12;
  localparam int DEFAULT_ITEM_WIDTH   = 16;
  localparam int DEFAULT_MIN_MATCH    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEFAULT_ITEM_WIDTH-DEFAULT_OFFSET_WIDTH-1:0] length;
    logic [DEFAULT_OFFSET_WIDTH-1:0]                    offset;
  } copy_item_t;

endpackage

// File: rtl/lzrw1_history_ram.sv
// History window storage: one write port, one registered read port.
// Read-during-write to the same address returns the old byte; the top forwards.
module lzrw1_history_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lzrw1_stream_decompressor.sv
// LZRW1 item-to-byte expander: literals pass through, copies replay the history
// window through a one-stage read pipeline with write-to-read forwarding.
module lzrw1_stream_decompressor
  import lzrw1_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
  parameter int ITEM_WIDTH   = DEFAULT_ITEM_WIDTH,
  parameter int MIN_MATCH    = DEFAULT_MIN_MATCH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ITEM_WIDTH-1:0] data_in,
  input  logic                  control_word_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [7:0]            decompressed_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  decompressor_busy,
  output logic                  error
);

  localparam int LEN_W = ITEM_WIDTH - OFFSET_WIDTH;
  localparam int DEPTH = 2**OFFSET_WIDTH;
  localparam int CNT_W = $clog2((2**LEN_W) + MIN_MATCH) + 1;

  localparam logic [OFFSET_WIDTH:0] FILL_MAX = (OFFSET_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [OFFSET_WIDTH-1:0] PTR_ONE = OFFSET_WIDTH'(1);

  state_t state_q, state_d;

  logic [OFFSET_WIDTH-1:0] wr_ptr, src_ptr;
  logic [OFFSET_WIDTH:0]   fill;
  logic [CNT_W-1:0]        rd_left, out_left;
  logic                    rd_vld;
  logic                    fwd_vld;
  logic [7:0]              fwd_byte;
  logic [7:0]              ram_q;

  logic [OFFSET_WIDTH-1:0] item_off;
  logic [LEN_W-1:0]        item_len;
  logic                    accept, lit_acc, cp_acc, bad_off, cp_start;
  logic                    out_free, load_cp, rd_issue, last_byte;
  logic                    wr_en;
  logic [7:0]              wr_data, cp_byte;

  assign item_off = data_in[OFFSET_WIDTH-1:0];
  assign item_len = data_in[ITEM_WIDTH-1:OFFSET_WIDTH];

  assign data_in_ready     = !reset && (state_q == IDLE) && (!out_valid || out_ready);
  assign decompressor_busy = (state_q != IDLE) || out_valid;

  assign accept   = data_in_valid && data_in_ready;
  assign lit_acc  = accept && !control_word_in;
  assign cp_acc   = accept && control_word_in;
  assign bad_off  = (item_off == '0) || ({1'b0, item_off} > fill);
  assign cp_start = cp_acc && !bad_off;

  // The byte in the read stage moves to the output register (and back into
  // history) whenever the output slot is free; a new read issues only if
  // the read stage will be empty, so a sink stall freezes the pipeline.
  assign out_free  = !out_valid || out_ready;
  assign load_cp   = (state_q == COPY) && rd_vld && out_free;
  assign rd_issue  = (state_q == COPY) && (rd_left != '0) && (!rd_vld || load_cp);
  assign last_byte = load_cp && (out_left == CNT_ONE);

  assign cp_byte = fwd_vld ? fwd_byte : ram_q;
  assign wr_en   = lit_acc || load_cp;
  assign wr_data = lit_acc ? data_in[7:0] : cp_byte;

  lzrw1_history_ram #(.ADDR_W(OFFSET_WIDTH)) u_hist (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_issue),
    .rd_addr (src_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cp_start)  state_d = COPY;
      COPY: if (last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      src_ptr  <= '0;
      fill     <= '0;
      rd_left  <= '0;
      out_left <= '0;
      rd_vld   <= 1'b0;
      fwd_vld  <= 1'b0;
      fwd_byte <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (fill != FILL_MAX) fill <= fill + (OFFSET_WIDTH+1)'(1);
      end
      if (cp_start) begin
        src_ptr  <= wr_ptr - item_off;
        rd_left  <= CNT_W'(item_len) + CNT_W'(MIN_MATCH);
        out_left <= CNT_W'(item_len) + CNT_W'(MIN_MATCH);
      end
      if (rd_issue) begin
        src_ptr <= src_ptr + PTR_ONE;
        rd_left <= rd_left - CNT_ONE;
        // Offset-1 overlap: the address read now is being written this same
        // edge, and the RAM would return the stale byte.
        fwd_vld  <= load_cp && (src_ptr == wr_ptr);
        fwd_byte <= cp_byte;
      end
      if (load_cp) out_left <= out_left - CNT_ONE;
      if (rd_issue)     rd_vld <= 1'b1;
      else if (load_cp) rd_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      decompressed_byte <= '0;
      error             <= 1'b0;
    end else begin
      if (cp_acc && bad_off) error <= 1'b1;
      if (lit_acc) begin
        out_valid         <= 1'b1;
        decompressed_byte <= data_in[7:0];
      end else if (load_cp) begin
        out_valid         <= 1'b1;
        decompressed_byte <= cp_byte;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
